// File: rtl/serial_reduce_pipe.sv
// ----------------------------------------------------------------------------
// serial_reduce_pipe
//   Pipelined WAY-bit to 1-bit reduction (AND / OR / XOR, optional final
//   inversion). One register bank follows every level of a binary reduction
//   tree; a valid/ready handshake with a global stall carries results out.
//
// Ports
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset
//   e1         operand vector (WAY bits), sampled on in_valid && in_ready
//   op         00 AND, 01 OR, 10 XOR, 11 reserved (sampled with e1)
//   inv        invert the final result (sampled with e1)
//   in_valid   upstream transaction valid
//   in_ready   block accepts a transaction this cycle
//   out        reduction result, valid when out_valid
//   out_valid  out holds a result
//   out_ready  downstream accepts out this cycle
//   op_err     result at the output was produced with reserved op 11
// ----------------------------------------------------------------------------
module serial_reduce_pipe #(
    parameter int unsigned WAY = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [WAY-1:0] e1,
    input  logic [1:0]     op,
    input  logic           inv,
    input  logic           in_valid,
    output logic           in_ready,
    output logic           out,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           op_err
);

    localparam int unsigned LAT = (WAY <= 2) ? 1 : $clog2(WAY);

    // Width of tree level k: ceil(WAY / 2^k).
    function automatic int unsigned lvl_width(input int unsigned k);
        int unsigned d;
        d = 1 << k;
        return (WAY + d - 1) / d;
    endfunction

    // One tree level: pairs bits (2i, 2i+1); an odd top bit passes through.
    // Bits at or above ceil(w/2) come out as zero.
    function automatic logic [WAY-1:0] reduce_level(input logic [WAY-1:0] v,
                                                    input int unsigned    w,
                                                    input logic [1:0]     o);
        logic [2*WAY-1:0] ext;
        logic [WAY-1:0]   res;
        logic             a;
        logic             b;
        ext = {{WAY{1'b0}}, v};
        res = '0;
        for (int unsigned i = 0; i < WAY; i++) begin
            a = ext[2*i];
            b = ext[2*i+1];
            if (2*i + 1 < w) begin
                case (o)
                    2'b00:   res[i] = a & b;
                    2'b01:   res[i] = a | b;
                    default: res[i] = a ^ b;  // op 11 is overridden at the last stage
                endcase
            end else if (2*i < w) begin
                res[i] = a;
            end
        end
        return res;
    endfunction

    // Stage registers: data/op/inv are unreset, valids and outputs are reset.
    logic [WAY-1:0] r_data [LAT];
    logic [1:0]     r_op   [LAT];
    logic [LAT-1:0] r_inv;
    logic [LAT-1:0] r_vld;
    logic           r_out;
    logic           r_err;

    // Per-stage inputs and the level each stage computes.
    logic [WAY-1:0] w_in_data [LAT];
    logic [1:0]     w_in_op   [LAT];
    logic [LAT-1:0] w_in_inv;
    logic [LAT-1:0] w_in_vld;
    logic [WAY-1:0] w_lvl     [LAT];
    logic           w_en;
    logic           w_tree;
    logic           w_rsvd;
    logic           w_res;

    // Global stall: everything advances together or nothing moves.
    assign w_en     = !r_vld[LAT-1] || out_ready;
    assign in_ready = w_en;

    always_comb begin
        w_in_data = '{default: '0};
        w_in_op   = '{default: '0};
        w_in_inv  = '0;
        w_in_vld  = '0;
        w_lvl     = '{default: '0};
        w_in_data[0] = e1;
        w_in_op[0]   = op;
        w_in_inv[0]  = inv;
        w_in_vld[0]  = in_valid;
        for (int unsigned s = 1; s < LAT; s++) begin
            w_in_data[s] = r_data[s-1];
            w_in_op[s]   = r_op[s-1];
            w_in_inv[s]  = r_inv[s-1];
            w_in_vld[s]  = r_vld[s-1];
        end
        for (int unsigned s = 0; s < LAT; s++) begin
            w_lvl[s] = reduce_level(w_in_data[s], lvl_width(s), w_in_op[s]);
        end
    end

    // Final stage: reserved op forces the tree result to 0, then invert once.
    assign w_tree = w_lvl[LAT-1][0];
    assign w_rsvd = (w_in_op[LAT-1] == 2'b11);
    assign w_res  = (w_rsvd ? 1'b0 : w_tree) ^ w_in_inv[LAT-1];

    always_ff @(posedge clk) begin
        if (w_en) begin
            r_data <= w_lvl;
            r_op   <= w_in_op;
            r_inv  <= w_in_inv;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
            r_out <= 1'b0;
            r_err <= 1'b0;
        end else if (w_en) begin
            r_vld <= w_in_vld;
            // Bubbles leave the last result in place so out never sees unreset data.
            if (w_in_vld[LAT-1]) begin
                r_out <= w_res;
                r_err <= w_rsvd;
            end
        end
    end

    assign out       = r_out;
    assign out_valid = r_vld[LAT-1];
    assign op_err    = r_err;

endmodule

// File: tb/tb_serial_reduce_pipe.sv
// ----------------------------------------------------------------------------
// tb_serial_reduce_pipe
//   Directed bench for serial_reduce_pipe at WAY = 8, 5 and 1. Each scenario
//   task drives its own vectors and compares against hand-computed values.
// ----------------------------------------------------------------------------
module tb_serial_reduce_pipe;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] e1_8 = '0;
    logic [1:0] op_8 = '0;
    logic       inv_8 = 1'b0, iv_8 = 1'b0, ordy_8 = 1'b1;
    logic       ir_8, out_8, ov_8, err_8;

    logic [4:0] e1_5 = '0;
    logic [1:0] op_5 = '0;
    logic       inv_5 = 1'b0, iv_5 = 1'b0, ordy_5 = 1'b1;
    logic       ir_5, out_5, ov_5, err_5;

    logic [0:0] e1_1 = '0;
    logic [1:0] op_1 = '0;
    logic       inv_1 = 1'b0, iv_1 = 1'b0, ordy_1 = 1'b1;
    logic       ir_1, out_1, ov_1, err_1;

    serial_reduce_pipe #(.WAY(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .e1(e1_8), .op(op_8), .inv(inv_8),
        .in_valid(iv_8), .in_ready(ir_8), .out(out_8), .out_valid(ov_8),
        .out_ready(ordy_8), .op_err(err_8)
    );

    serial_reduce_pipe #(.WAY(5)) u_dut5 (
        .clk(clk), .rst_n(rst_n), .e1(e1_5), .op(op_5), .inv(inv_5),
        .in_valid(iv_5), .in_ready(ir_5), .out(out_5), .out_valid(ov_5),
        .out_ready(ordy_5), .op_err(err_5)
    );

    serial_reduce_pipe #(.WAY(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .e1(e1_1), .op(op_1), .inv(inv_1),
        .in_valid(iv_1), .in_ready(ir_1), .out(out_1), .out_valid(ov_1),
        .out_ready(ordy_1), .op_err(err_1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic sel_ov(input int sel);
        case (sel)
            8:       return ov_8;
            5:       return ov_5;
            default: return ov_1;
        endcase
    endfunction

    // Drives one transaction into the selected DUT (out_ready held high) and
    // returns the result plus the number of edges from acceptance to out_valid.
    task automatic run_one(input int sel, input logic [7:0] e, input logic [1:0] o,
                           input logic i, output logic got_out, output logic got_err,
                           output int lat);
        int cyc;
        case (sel)
            8:       begin e1_8 = e;      op_8 = o; inv_8 = i; iv_8 = 1'b1; end
            5:       begin e1_5 = e[4:0]; op_5 = o; inv_5 = i; iv_5 = 1'b1; end
            default: begin e1_1 = e[0:0]; op_1 = o; inv_1 = i; iv_1 = 1'b1; end
        endcase
        step();
        iv_8 = 1'b0;
        iv_5 = 1'b0;
        iv_1 = 1'b0;
        cyc = 0;
        while (!sel_ov(sel) && cyc < 10) begin
            step();
            cyc++;
        end
        case (sel)
            8:       begin got_out = out_8; got_err = err_8; end
            5:       begin got_out = out_5; got_err = err_5; end
            default: begin got_out = out_1; got_err = err_1; end
        endcase
        lat = cyc;
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({ov_8, out_8, err_8} !== 3'b000) begin
            errors++;
            $display("FAIL reset_hold8: ov/out/err=%b required 000", {ov_8, out_8, err_8});
        end
        checks++;
        if ({ov_5, ov_1} !== 2'b00) begin
            errors++;
            $display("FAIL reset_hold_ov: ov5/ov1=%b required 00", {ov_5, ov_1});
        end
        #4 rst_n = 1'b1;
        step();
        checks++;
        if ({ir_8, ir_5, ir_1} !== 3'b111) begin
            errors++;
            $display("FAIL reset_ready: in_ready 8/5/1=%b required 111", {ir_8, ir_5, ir_1});
        end
        checks++;
        if ({ov_8, out_8, err_8} !== 3'b000) begin
            errors++;
            $display("FAIL reset_release8: ov/out/err=%b required 000", {ov_8, out_8, err_8});
        end
    endtask

    task automatic test_and();
        logic [7:0] ev [3];
        logic       iv [3];
        logic       ex [3];
        logic       g_out, g_err;
        int         lat;
        ev = '{8'hFF, 8'hFE, 8'hFE};
        iv = '{1'b0, 1'b0, 1'b1};
        ex = '{1'b1, 1'b0, 1'b1};
        for (int k = 0; k < 3; k++) begin
            run_one(8, ev[k], 2'b00, iv[k], g_out, g_err, lat);
            checks++;
            if (g_out !== ex[k] || g_err !== 1'b0) begin
                errors++;
                $display("FAIL and8[%0d]: out=%b err=%b required out=%b err=0",
                         k, g_out, g_err, ex[k]);
            end
            checks++;
            if (lat != 2) begin
                errors++;
                $display("FAIL and8_latency[%0d]: %0d edges required 2", k, lat);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] ev [4];
        logic [1:0] ov [4];
        logic       iv [4];
        logic       ex [4];
        logic       got [$];
        int         when [$];
        ev = '{8'h00, 8'h10, 8'h07, 8'h0F};
        ov = '{2'b01, 2'b01, 2'b10, 2'b10};
        iv = '{1'b0, 1'b0, 1'b0, 1'b1};
        ex = '{1'b0, 1'b1, 1'b1, 1'b1};
        ordy_8 = 1'b1;
        for (int k = 0; k < 12; k++) begin
            if (ov_8) begin
                got.push_back(out_8);
                when.push_back(k);
            end
            if (k < 4) begin
                e1_8 = ev[k]; op_8 = ov[k]; inv_8 = iv[k]; iv_8 = 1'b1;
            end else begin
                iv_8 = 1'b0;
            end
            step();
        end
        checks++;
        if (got.size() != 4) begin
            errors++;
            $display("FAIL b2b_count: %0d results required 4", got.size());
        end
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (j >= got.size()) begin
                errors++;
                $display("FAIL b2b_result[%0d]: missing required %b", j, ex[j]);
            end else if (got[j] !== ex[j] || when[j] != 3 + j) begin
                errors++;
                $display("FAIL b2b_result[%0d]: out=%b at cycle %0d required %b at cycle %0d",
                         j, got[j], when[j], ex[j], 3 + j);
            end
        end
    endtask

    task automatic test_odd_way();
        logic g_out, g_err;
        int   lat;
        run_one(5, 8'h10, 2'b10, 1'b0, g_out, g_err, lat);
        checks++;
        if (g_out !== 1'b1 || lat != 2) begin
            errors++;
            $display("FAIL way5_xor_top: out=%b lat=%0d required out=1 lat=2", g_out, lat);
        end
        run_one(5, 8'h1F, 2'b00, 1'b0, g_out, g_err, lat);
        checks++;
        if (g_out !== 1'b1) begin
            errors++;
            $display("FAIL way5_and_ones: out=%b required 1", g_out);
        end
        run_one(5, 8'h0F, 2'b00, 1'b0, g_out, g_err, lat);
        checks++;
        if (g_out !== 1'b0) begin
            errors++;
            $display("FAIL way5_and_top0: out=%b required 0", g_out);
        end
        run_one(1, 8'h01, 2'b00, 1'b1, g_out, g_err, lat);
        checks++;
        if (g_out !== 1'b0 || lat != 0) begin
            errors++;
            $display("FAIL way1_inv1: out=%b lat=%0d required out=0 lat=0", g_out, lat);
        end
        run_one(1, 8'h00, 2'b01, 1'b1, g_out, g_err, lat);
        checks++;
        if (g_out !== 1'b1) begin
            errors++;
            $display("FAIL way1_inv0: out=%b required 1", g_out);
        end
    endtask

    task automatic test_reserved_op();
        logic g_out, g_err;
        int   lat;
        run_one(8, 8'hAA, 2'b11, 1'b0, g_out, g_err, lat);
        checks++;
        if (g_out !== 1'b0 || g_err !== 1'b1) begin
            errors++;
            $display("FAIL rsvd_inv0: out=%b err=%b required out=0 err=1", g_out, g_err);
        end
        run_one(8, 8'h55, 2'b11, 1'b1, g_out, g_err, lat);
        checks++;
        if (g_out !== 1'b1 || g_err !== 1'b1) begin
            errors++;
            $display("FAIL rsvd_inv1: out=%b err=%b required out=1 err=1", g_out, g_err);
        end
        run_one(8, 8'hFF, 2'b00, 1'b0, g_out, g_err, lat);
        checks++;
        if (g_out !== 1'b1 || g_err !== 1'b0) begin
            errors++;
            $display("FAIL rsvd_clear: out=%b err=%b required out=1 err=0", g_out, g_err);
        end
    endtask

    task automatic test_stall();
        logic [7:0] ev [6];
        logic [1:0] ov [6];
        logic       iv [6];
        logic       ex [6];
        logic       got [$];
        int         idx;
        logic       acc, prev_stall, prev_out;
        ev = '{8'hFF, 8'h00, 8'h01, 8'h03, 8'h80, 8'h7F};
        ov = '{2'b00, 2'b01, 2'b10, 2'b10, 2'b01, 2'b00};
        iv = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        ex = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        idx = 0;
        prev_stall = 1'b0;
        prev_out = 1'b0;
        for (int c = 0; c < 40; c++) begin
            ordy_8 = !(c >= 4 && c < 8);
            if (idx < 6) begin
                e1_8 = ev[idx]; op_8 = ov[idx]; inv_8 = iv[idx]; iv_8 = 1'b1;
            end else begin
                iv_8 = 1'b0;
            end
            #1;
            if (prev_stall) begin
                checks++;
                if (ov_8 !== 1'b1 || out_8 !== prev_out) begin
                    errors++;
                    $display("FAIL stall_hold[c=%0d]: ov=%b out=%b required ov=1 out=%b",
                             c, ov_8, out_8, prev_out);
                end
            end
            if (ov_8 && !ordy_8) begin
                checks++;
                if (ir_8 !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_ready[c=%0d]: in_ready=%b required 0", c, ir_8);
                end
            end
            if (ov_8 && ordy_8) got.push_back(out_8);
            prev_stall = ov_8 && !ordy_8;
            prev_out = out_8;
            acc = iv_8 && ir_8;
            @(posedge clk);
            #1;
            if (acc) idx++;
        end
        ordy_8 = 1'b1;
        iv_8 = 1'b0;
        checks++;
        if (idx != 6 || got.size() != 6) begin
            errors++;
            $display("FAIL stall_count: accepted=%0d delivered=%0d required 6/6", idx, got.size());
        end
        for (int j = 0; j < 6; j++) begin
            checks++;
            if (j >= got.size()) begin
                errors++;
                $display("FAIL stall_result[%0d]: missing required %b", j, ex[j]);
            end else if (got[j] !== ex[j]) begin
                errors++;
                $display("FAIL stall_result[%0d]: out=%b required %b", j, got[j], ex[j]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] ev [3];
        logic [1:0] ov [3];
        logic       stale;
        ev = '{8'h00, 8'hFF, 8'hFF};
        ov = '{2'b11, 2'b00, 2'b01};
        ordy_8 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            e1_8 = ev[k]; op_8 = ov[k]; inv_8 = (k == 0); iv_8 = 1'b1;
            step();
        end
        iv_8 = 1'b0;
        checks++;
        if ({ov_8, out_8, err_8} !== 3'b111) begin
            errors++;
            $display("FAIL rstmid_pre: ov/out/err=%b required 111", {ov_8, out_8, err_8});
        end
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if ({ov_8, out_8, err_8} !== 3'b000) begin
            errors++;
            $display("FAIL rstmid_async: ov/out/err=%b required 000", {ov_8, out_8, err_8});
        end
        #2 rst_n = 1'b1;
        stale = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (ov_8 || out_8 || err_8) stale = 1'b1;
        end
        checks++;
        if (stale !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_stale: stale result seen=%b required 0", stale);
        end
    endtask

    initial begin
        test_reset();
        test_and();
        test_back_to_back();
        test_odd_way();
        test_reserved_op();
        test_stall();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
